// File: rtl/ethtx_pkg.sv
// Shared definitions for the Ethernet transmit-frame loader: sizes, state encoding, byte-count helper.
// Optional feature macro: ETHTXLOAD_PAD_EN (adds the PAD state for short-frame zero padding).
package ethtx_pkg;

  localparam int unsigned DEF_MAXBYTES = 1514;
  localparam int unsigned DEF_MINBYTES = 60;
  localparam int unsigned BUFWORDS     = 512;
  localparam int unsigned MAXWORDS     = 758;

  localparam int unsigned AW = 9;   // buffer entry address
  localparam int unsigned DW = 32;  // buffer entry width
  localparam int unsigned WW = 16;  // DMA word width
  localparam int unsigned CW = 11;  // txcntb width
  localparam int unsigned NW = 12;  // byte-count arithmetic width
  localparam int unsigned PW = 10;  // word pointer width (up to 759 words)

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef ETHTXLOAD_PAD_EN
    S_PAD,
`endif
    S_SEND,
    S_WAITDONE
  } state_e;

  // Frame byte count from word count, minus skipped first byte and unused last byte
  function automatic logic [NW-1:0] byte_count(input logic [PW-1:0] words,
                                               input logic h, input logic l);
    return NW'({words, 1'b0}) - NW'(h) - NW'(l);
  endfunction

endpackage

// File: rtl/ethtxload_if.sv
// DMA-to-loader word stream with frame delimiters and H/L byte qualifiers.
interface ethtxload_if;
  import ethtx_pkg::*;

  logic [WW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          wr_first;
  logic          wr_last;
  logic          hbit;
  logic          lbit;

  modport master (output wr_data, wr_valid, wr_first, wr_last, hbit, lbit,
                  input  wr_ready);
  modport slave  (input  wr_data, wr_valid, wr_first, wr_last, hbit, lbit,
                  output wr_ready);
endinterface

// File: rtl/ethtx_dpram.sv
// 512x32 simple dual-port transmit buffer: 16-bit lane write enables, registered read.
module ethtx_dpram
  import ethtx_pkg::*;
(
  input  logic          clk,
  input  logic [1:0]    we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [BUFWORDS];
  logic [DW-1:0] rdata_q;

  // Lane writes and registered read share the clock
  always_ff @(posedge clk) begin
    if (we_i[0]) mem_q[waddr_i][15:0]  <= wdata_i[15:0];
    if (we_i[1]) mem_q[waddr_i][31:16] <= wdata_i[31:16];
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ethtxload.sv
// Ethernet transmit-frame loader: packs DMA words into the transmit buffer, computes the
// byte count / skip flag and hands the frame to the transmitter via txena/txdone.
// Optional feature macro: ETHTXLOAD_PAD_EN (zero-pad short frames up to MINBYTES).
module ethtxload
  import ethtx_pkg::*;
#(
  parameter int unsigned MAXBYTES = DEF_MAXBYTES
`ifdef ETHTXLOAD_PAD_EN
  , parameter int unsigned MINBYTES = DEF_MINBYTES
`endif
) (
  input  logic            clk,
  input  logic            clr,
  ethtxload_if.slave      wr,
  input  logic [AW-1:0]   txbaddr,
  output logic [DW-1:0]   txbdata,
  output logic [CW-1:0]   txcntb,
  output logic            skipb,
  output logic            txena,
  input  logic            txdone,
  output logic            busy,
  output logic            done,
  output logic            err_len
);

  state_e        state_q, state_d, end_state_c;
  logic [PW-1:0] wptr_q;
  logic          drop_q;
  logic          skipb_q, txena_q, done_q, err_q, wr_ready_q, busy_q;
  logic [CW-1:0] txcntb_q;

  logic          xfer_c, start_c, load_c, accept_c, end_c;
  logic          hsel_c, bad_len_c, overflow_c;
  logic [PW-1:0] widx_c, wcnt_c;
  logic [NW-1:0] nbytes_c;
  logic [WW-1:0] wdata16_c;
  logic [1:0]    ram_we_c;
  logic [AW-1:0] ram_waddr_c;
  logic [DW-1:0] ram_wdata_c;

`ifdef ETHTXLOAD_PAD_EN
  logic [AW-1:0] pad_addr_q, pad_end_q;
  logic [1:0]    pad_we_q;
  logic          pad_need_c;
  logic [NW-1:0] pad_last_byte_c;
`endif

  // Word acceptance and running frame length
  assign xfer_c     = wr.wr_valid & wr_ready_q;
  assign start_c    = xfer_c & (state_q == S_IDLE) & wr.wr_first;
  assign load_c     = xfer_c & (state_q == S_LOAD);
  assign accept_c   = start_c | (load_c & ~drop_q);
  assign end_c      = (start_c | load_c) & wr.wr_last;
  assign widx_c     = start_c ? '0 : wptr_q;
  assign wcnt_c     = widx_c + PW'(1);
  assign hsel_c     = start_c ? wr.hbit : skipb_q;
  assign nbytes_c   = byte_count(wcnt_c, hsel_c, wr.lbit);
  assign bad_len_c  = (nbytes_c == '0) || (nbytes_c > NW'(MAXBYTES));
  assign overflow_c = accept_c & ~wr.wr_last & (wcnt_c > PW'(MAXWORDS));

`ifdef ETHTXLOAD_PAD_EN
  assign pad_need_c      = nbytes_c < NW'(MINBYTES);
  assign pad_last_byte_c = NW'(MINBYTES) + NW'(hsel_c) - NW'(1);
`endif

  // Destination state once the last word of a valid-length check arrives
  always_comb begin
    end_state_c = S_SEND;
    if (bad_len_c) end_state_c = S_IDLE;
`ifdef ETHTXLOAD_PAD_EN
    else if (pad_need_c) end_state_c = S_PAD;
`endif
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_c) state_d = wr.wr_last ? end_state_c : S_LOAD;
      S_LOAD:     if (end_c)   state_d = drop_q ? S_IDLE : end_state_c;
`ifdef ETHTXLOAD_PAD_EN
      S_PAD:      if (pad_addr_q == pad_end_q) state_d = S_SEND;
`endif
      S_SEND:     if (txdone)  state_d = S_WAITDONE;
      S_WAITDONE: if (!txdone) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Buffer write port: DMA words during load, zero fill during padding
  always_comb begin
    wdata16_c = wr.wr_data;
`ifdef ETHTXLOAD_PAD_EN
    if (wr.wr_last && wr.lbit) wdata16_c[15:8] = 8'h00;
`endif
    ram_we_c    = 2'b00;
    ram_waddr_c = widx_c[PW-1:1];
    ram_wdata_c = {wdata16_c, wdata16_c};
    if (accept_c) ram_we_c = widx_c[0] ? 2'b10 : 2'b01;
`ifdef ETHTXLOAD_PAD_EN
    if (state_q == S_PAD) begin
      ram_we_c    = pad_we_q;
      ram_waddr_c = pad_addr_q;
      ram_wdata_c = '0;
    end
`endif
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      drop_q     <= 1'b0;
      skipb_q    <= 1'b0;
      txcntb_q   <= '0;
      txena_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_ready_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ETHTXLOAD_PAD_EN
      pad_addr_q <= '0;
      pad_end_q  <= '0;
      pad_we_q   <= 2'b00;
`endif
    end else begin
      state_q    <= state_d;
      wr_ready_q <= (state_d == S_IDLE) || (state_d == S_LOAD);
      busy_q     <= (state_d != S_IDLE);
      txena_q    <= (state_d == S_SEND);
      done_q     <= (state_q == S_WAITDONE) && (state_d == S_IDLE);
      err_q      <= overflow_c | (end_c & ~drop_q & bad_len_c);

      if (start_c)    skipb_q <= wr.hbit;
      if (accept_c)   wptr_q  <= wcnt_c;
      if (overflow_c) drop_q  <= 1'b1;
      if (end_c)      drop_q  <= 1'b0;

      if (end_c && !drop_q && !bad_len_c) begin
`ifdef ETHTXLOAD_PAD_EN
        if (pad_need_c) begin
          txcntb_q   <= CW'(NW'(2048) - NW'(MINBYTES));
          pad_addr_q <= wcnt_c[PW-1:1];
          pad_we_q   <= wcnt_c[0] ? 2'b10 : 2'b11;
          pad_end_q  <= AW'(pad_last_byte_c >> 2);
        end else
`endif
        txcntb_q <= CW'(NW'(2048) - nbytes_c);
      end

`ifdef ETHTXLOAD_PAD_EN
      if (state_q == S_PAD) begin
        pad_we_q <= 2'b11;
        if (pad_addr_q != pad_end_q) pad_addr_q <= pad_addr_q + AW'(1);
      end
`endif
    end
  end

  ethtx_dpram u_buf (
    .clk     (clk),
    .we_i    (ram_we_c),
    .waddr_i (ram_waddr_c),
    .wdata_i (ram_wdata_c),
    .raddr_i (txbaddr),
    .rdata_o (txbdata)
  );

  assign wr.wr_ready = wr_ready_q;
  assign txcntb      = txcntb_q;
  assign skipb       = skipb_q;
  assign txena       = txena_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_len     = err_q;

endmodule

// File: tb/tb_ethtxload.sv
// Self-checking bench for ethtxload: scoreboard of expected frame outcomes plus a buffer model.
module tb_ethtxload;

  logic        clk = 1'b0;
  logic        clr;
  logic [8:0]  txbaddr;
  logic [31:0] txbdata;
  logic [10:0] txcntb;
  logic        skipb, txena, txdone, busy, done, err_len;

  ethtxload_if bus();

  ethtxload dut (
    .clk     (clk),
    .clr     (clr),
    .wr      (bus),
    .txbaddr (txbaddr),
    .txbdata (txbdata),
    .txcntb  (txcntb),
    .skipb   (skipb),
    .txena   (txena),
    .txdone  (txdone),
    .busy    (busy),
    .done    (done),
    .err_len (err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [10:0] cntb;
    bit          skip;
    int          nent;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] fw[$];
  logic [31:0] mem_m [512];
  logic [1:0]  mem_v [512];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void mem_put(input int k, input logic [15:0] d);
    if (k % 2 == 1) begin
      mem_m[k/2][31:16] = d;
      mem_v[k/2][1] = 1'b1;
    end else begin
      mem_m[k/2][15:0] = d;
      mem_v[k/2][0] = 1'b1;
    end
  endfunction

  // Reference model for a complete frame held in fw; pushes the expected outcome
  task automatic model_frame(input bit h, input bit l);
    int   w = fw.size();
    int   n = 2*w - int'(h) - int'(l);
    exp_t e;
    logic [15:0] d;
    e.skip = h;
    e.err  = (n == 0) || (n > 1514);
    e.cntb = 11'(2048 - n);
    e.nent = (w + 1) / 2;
    for (int k = 0; k < w; k++) begin
      d = fw[k];
`ifdef ETHTXLOAD_PAD_EN
      if (k == w-1 && l) d[15:8] = 8'h00;
`endif
      mem_put(k, d);
    end
`ifdef ETHTXLOAD_PAD_EN
    if (!e.err && n < 60) begin
      int pend = (60 + int'(h) - 1) / 4;
      for (int k = w; k < 2*(pend+1); k++) mem_put(k, 16'h0000);
      e.nent = pend + 1;
      e.cntb = 11'(2048 - 60);
    end
`endif
    exp_q.push_back(e);
  endtask

  task automatic drive_word(input logic [15:0] d, input bit f, input bit l, input bit h, input bit lb);
    int cyc = 0;
    @(negedge clk);
    bus.wr_data  = d;
    bus.wr_valid = 1'b1;
    bus.wr_first = f;
    bus.wr_last  = l;
    bus.hbit     = h;
    bus.lbit     = lb;
    while (!bus.wr_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.wr_ready) check("wr_ready_timeout", 32'(bus.wr_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
  endtask

  task automatic send_frame(input bit h, input bit l);
    for (int i = 0; i < fw.size(); i++)
      drive_word(fw[i], i == 0, i == fw.size()-1, h, l);
  endtask

  // Pop the expected outcome and act as the transmitter
  task automatic check_outcome(input string name);
    exp_t e = exp_q.pop_front();
    int   cyc = 0;
    bit   seen_tx = 0, seen_err = 0;
    logic [31:0] mask;
    while (cyc < 64) begin
      if (txena)   seen_tx  = 1;
      if (err_len) seen_err = 1;
      if (seen_tx || seen_err) break;
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_err_len"}, 32'(seen_err), 32'(e.err));
    check({name, "_txena"},   32'(seen_tx),  32'(!e.err));
    if (seen_tx) begin
      check({name, "_txcntb"}, 32'(txcntb), 32'(e.cntb));
      check({name, "_skipb"},  32'(skipb),  32'(e.skip));
      for (int i = 0; i < e.nent; i++) begin
        @(negedge clk);
        txbaddr = 9'(i);
        @(posedge clk); #1;
        mask = {{16{mem_v[i][1]}}, {16{mem_v[i][0]}}};
        if (mask != 32'h0)
          check($sformatf("%s_entry%0d", name, i), txbdata & mask, mem_m[i] & mask);
      end
      check({name, "_txena_hold"}, 32'(txena), 32'd1);
      @(negedge clk); txdone = 1'b1;
      @(posedge clk); #1;
      check({name, "_txena_drop"}, 32'(txena), 32'd0);
      check({name, "_done_early"}, 32'(done), 32'd0);
      @(negedge clk); txdone = 1'b0;
      @(posedge clk); #1;
      check({name, "_done"}, 32'(done), 32'd1);
      check({name, "_busy_end"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      check({name, "_done_pulse"}, 32'(done), 32'd0);
    end else begin
      check({name, "_txena_err"}, 32'(txena), 32'd0);
      @(posedge clk); #1;
      check({name, "_err_pulse"}, 32'(err_len), 32'd0);
      check({name, "_busy_err"},  32'(busy), 32'd0);
      check({name, "_txena_after"}, 32'(txena), 32'd0);
    end
  endtask

  task automatic rand_frame(input int w);
    fw.delete();
    for (int i = 0; i < w; i++) fw.push_back(16'($urandom));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    foreach (mem_v[i]) mem_v[i] = 2'b00;
    bus.wr_data = '0; bus.wr_valid = 0; bus.wr_first = 0; bus.wr_last = 0;
    bus.hbit = 0; bus.lbit = 0;
    txbaddr = '0; txdone = 0; clr = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_txena",    32'(txena),        32'd0);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_done",     32'(done),         32'd0);
    check("rst_err_len",  32'(err_len),      32'd0);
    check("rst_skipb",    32'(skipb),        32'd0);
    check("rst_txcntb",   32'(txcntb),       32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    @(negedge clk); clr = 0;

    // Word without wr_first in IDLE is ignored
    drive_word(16'h1234, 0, 0, 0, 0);
    check("stray_busy", 32'(busy), 32'd0);

    // Four words, no skip bits
    fw = '{16'hAABB, 16'hCCDD, 16'hEEFF, 16'h1122};
    model_frame(0, 0); send_frame(0, 0); check_outcome("frm4");

    // Three words with both H and L bits
    fw = '{16'h0102, 16'h0304, 16'h0506};
    model_frame(1, 1); send_frame(1, 1); check_outcome("frm3hl");

    // Single-word frame with n=0
    fw = '{16'h5A5A};
    model_frame(1, 1); send_frame(1, 1); check_outcome("frm1zero");

    // Overflow: 759 words without wr_last, then trailing words ending in wr_last
    rand_frame(759);
    for (int i = 0; i < 759; i++) begin
      drive_word(fw[i], i == 0, 0, 0, 0);
      mem_put(i, fw[i]);
      if (i == 757) check("ovf_no_err_758", 32'(err_len), 32'd0);
      if (i == 758) check("ovf_err_759",    32'(err_len), 32'd1);
    end
    drive_word(16'hDEAD, 0, 0, 0, 0);
    check("ovf_err_pulse", 32'(err_len), 32'd0);
    check("ovf_busy_drop", 32'(busy), 32'd1);
    drive_word(16'hBEEF, 0, 1, 0, 0);
    check("ovf_busy_idle", 32'(busy), 32'd0);
    check("ovf_no_txena",  32'(txena), 32'd0);
    check("ovf_no_err2",   32'(err_len), 32'd0);

    // Maximum-length boundary frames
    rand_frame(757); model_frame(0, 0); send_frame(0, 0); check_outcome("max757");
    rand_frame(758); model_frame(1, 1); send_frame(1, 1); check_outcome("max758hl");
    rand_frame(758); model_frame(0, 0); send_frame(0, 0); check_outcome("over758");

    // Reset in the middle of SEND
    rand_frame(4); model_frame(0, 0); send_frame(0, 0);
    void'(exp_q.pop_front());
    cyc = 0;
    while (!txena && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("clr_txena_up", 32'(txena), 32'd1);
    @(negedge clk); clr = 1;
    @(posedge clk); #1;
    check("clr_txena", 32'(txena), 32'd0);
    check("clr_busy",  32'(busy),  32'd0);
    @(negedge clk); clr = 0;
    repeat (3) @(posedge clk);
    #1;
    check("clr_no_done", 32'(done), 32'd0);

    // Short frame n=20 (padded when the option is built in)
    rand_frame(10); model_frame(0, 0); send_frame(0, 0); check_outcome("short20");

    // Odd byte count with unused last byte
    rand_frame(5); model_frame(0, 1); send_frame(0, 1); check_outcome("short9");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
